mc_control_unit: RTL and testbench

//  Multi-cycle MIPS control FSM that drives the 3-bit ALU select and all datapath enables.

---
 rtl/mc_ctrl_pkg.sv | 50 +++++
 rtl/alu_op_decoder.sv | 28 ++
 rtl/mc_control_unit.sv | 171 +++++++++++++++++
 tb/tb_mc_control_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared encodings for the multi-cycle MIPS control unit
package mc_ctrl_pkg;

    localparam logic [2:0] ALU_PASS_B = 3'b000;
    localparam logic [2:0] ALU_SLT    = 3'b001;
    localparam logic [2:0] ALU_ADD    = 3'b010;
    localparam logic [2:0] ALU_SUB    = 3'b011;
    localparam logic [2:0] ALU_PASS_A = 3'b100;
    localparam logic [2:0] ALU_MUL    = 3'b101;
    localparam logic [2:0] ALU_EQ     = 3'b110;
    localparam logic [2:0] ALU_AND    = 3'b111;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_MUL = 6'h18;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC     = 4'd6,
        S_ALU_WB   = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_ADDI_EX  = 4'd10,
        S_ADDI_WB  = 4'd11
    } state_e;

endpackage

// File: rtl/alu_op_decoder.sv
// rtl/alu_op_decoder.sv - R-type funct to ALU select decode with legality flag
module alu_op_decoder
    import mc_ctrl_pkg::*;
#(
    parameter bit MUL_EN = 1'b1
) (
    input  logic [5:0] funct,
    output logic [2:0] alu_select,
    output logic       legal
);

    always_comb begin
        alu_select = ALU_ADD;
        legal      = 1'b1;
        case (funct)
            FN_ADD: alu_select = ALU_ADD;
            FN_SUB: alu_select = ALU_SUB;
            FN_AND: alu_select = ALU_AND;
            FN_SLT: alu_select = ALU_SLT;
            FN_MUL: begin
                if (MUL_EN) alu_select = ALU_MUL;
                else        legal      = 1'b0;
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// rtl/mc_control_unit.sv - multi-cycle MIPS control FSM driving ALU select and datapath enables
module mc_control_unit
    import mc_ctrl_pkg::*;
#(
    parameter bit MUL_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [2:0] alu_select,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       illegal_instr,
    output logic       instr_retired,
    output logic [3:0] state_o
);

    state_e     state_q;
    state_e     state_d;
    logic [5:0] op_q;
    logic [5:0] funct_q;
    logic [2:0] dec_select;
    logic       dec_legal;

    alu_op_decoder #(.MUL_EN(MUL_EN)) u_dec (
        .funct      (funct_q),
        .alu_select (dec_select),
        .legal      (dec_legal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            op_q    <= '0;
            funct_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                op_q    <= opcode;
                funct_q <= funct;
            end
        end
    end

    assign state_o = state_q;

    always_comb begin
        state_d       = S_FETCH;
        alu_select    = ALU_ADD;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REG;
        pc_we         = 1'b0;
        pc_src        = PCSRC_ALU;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        illegal_instr = 1'b0;
        instr_retired = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_we    = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target is computed speculatively into ALUOut here.
                alu_src_b = SRCB_IMM_SH2;
                case (opcode)
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    default:      illegal_instr = 1'b1;
                endcase
            end
            S_EXEC: begin
                alu_src_a  = 1'b1;
                alu_select = dec_select;
                if (dec_legal) state_d = S_ALU_WB;
                else           illegal_instr = 1'b1;
            end
            S_ALU_WB: begin
                reg_dst       = 1'b1;
                reg_write     = 1'b1;
                instr_retired = 1'b1;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
                state_d  = mem_ready ? S_MEM_WB : S_MEM_RD;
            end
            S_MEM_WB: begin
                mem_to_reg    = 1'b1;
                reg_write     = 1'b1;
                instr_retired = 1'b1;
            end
            S_MEM_WR: begin
                iord          = 1'b1;
                mem_write     = 1'b1;
                instr_retired = mem_ready;
                state_d       = mem_ready ? S_FETCH : S_MEM_WR;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_select    = ALU_EQ;
                pc_src        = PCSRC_ALUOUT;
                pc_we         = zero;
                instr_retired = 1'b1;
            end
            S_JUMP: begin
                pc_src        = PCSRC_JUMP;
                pc_we         = 1'b1;
                instr_retired = 1'b1;
            end
            S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write     = 1'b1;
                instr_retired = 1'b1;
            end
            default: alu_select = ALU_PASS_B;
        endcase
        // Reset overrides every strobe so an abandoned instruction cannot write.
        if (reset) begin
            alu_select    = ALU_ADD;
            alu_src_a     = 1'b0;
            alu_src_b     = SRCB_REG;
            pc_we         = 1'b0;
            pc_src        = PCSRC_ALU;
            iord          = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            reg_dst       = 1'b0;
            mem_to_reg    = 1'b0;
            reg_write     = 1'b0;
            illegal_instr = 1'b0;
            instr_retired = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_control_unit.sv
// tb/tb_mc_control_unit.sv - directed vector bench for mc_control_unit
module tb_mc_control_unit;
    import mc_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h20;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;

    logic [2:0] alu_select;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
    logic       illegal_instr, instr_retired;
    logic [3:0] state_o;

    logic [2:0] n_alu_select;
    logic       n_alu_src_a;
    logic [1:0] n_alu_src_b;
    logic       n_pc_we;
    logic [1:0] n_pc_src;
    logic       n_iord, n_mem_read, n_mem_write, n_ir_write, n_reg_dst, n_mem_to_reg, n_reg_write;
    logic       n_illegal_instr, n_instr_retired;
    logic [3:0] n_state_o;

    always #5 clk = ~clk;

    mc_control_unit #(.MUL_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .alu_select(alu_select), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .pc_we(pc_we), .pc_src(pc_src), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .illegal_instr(illegal_instr), .instr_retired(instr_retired), .state_o(state_o)
    );

    mc_control_unit #(.MUL_EN(1'b0)) dut_nm (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .alu_select(n_alu_select), .alu_src_a(n_alu_src_a),
        .alu_src_b(n_alu_src_b), .pc_we(n_pc_we), .pc_src(n_pc_src), .iord(n_iord),
        .mem_read(n_mem_read), .mem_write(n_mem_write), .ir_write(n_ir_write),
        .reg_dst(n_reg_dst), .mem_to_reg(n_mem_to_reg), .reg_write(n_reg_write),
        .illegal_instr(n_illegal_instr), .instr_retired(n_instr_retired), .state_o(n_state_o)
    );

    logic [21:0] act;
    assign act = {state_o, alu_select, alu_src_a, alu_src_b, pc_we, pc_src,
                  iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                  illegal_instr, instr_retired};

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        rdy;
        logic [21:0] exp;
    } vec_t;

    vec_t vecs[$];
    logic [5:0] cur_op, cur_fn;
    logic       cur_z;
    int checks = 0;
    int errors = 0;

    // fl = {iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, illegal, retired}
    function automatic logic [21:0] pk(input logic [3:0] st, input logic [2:0] sel,
                                       input logic a, input logic [1:0] b, input logic pwe,
                                       input logic [1:0] psrc, input logic [8:0] fl);
        return {st, sel, a, b, pwe, psrc, fl};
    endfunction

    function automatic logic [21:0] e_fetch(input logic rdy);
        return pk(4'd0, 3'b010, 1'b0, 2'b01, rdy, 2'b00, {1'b0, 1'b1, 1'b0, rdy, 5'b0});
    endfunction

    function automatic logic [21:0] e_decode(input logic ill);
        return pk(4'd1, 3'b010, 1'b0, 2'b11, 1'b0, 2'b00, {8'b0, 1'b0} | {7'b0, ill, 1'b0});
    endfunction

    task automatic row(input logic rst, input logic rdy, input logic [21:0] exp);
        vec_t v;
        v.rst = rst; v.op = cur_op; v.fn = cur_fn; v.z = cur_z; v.rdy = rdy; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic begin_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
        cur_op = op; cur_fn = fn; cur_z = z;
        row(1'b0, 1'b1, e_fetch(1'b1));
        row(1'b0, 1'b1, e_decode(1'b0));
    endtask

    task automatic rtype(input logic [5:0] fn, input logic [2:0] sel);
        begin_instr(6'h00, fn, 1'b0);
        row(1'b0, 1'b1, pk(4'd6, sel, 1'b1, 2'b00, 1'b0, 2'b00, 9'b0));
        row(1'b0, 1'b1, pk(4'd7, 3'b010, 1'b0, 2'b00, 1'b0, 2'b00, 9'b000010101));
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        cur_op = 6'h00; cur_fn = 6'h20; cur_z = 1'b0;
        // reset state
        row(1'b1, 1'b1, pk(4'd0, 3'b010, 1'b0, 2'b00, 1'b0, 2'b00, 9'b0));
        rtype(6'h20, 3'b010);
        rtype(6'h22, 3'b011);
        rtype(6'h24, 3'b111);
        rtype(6'h2A, 3'b001);
        rtype(6'h18, 3'b101);
        begin_instr(6'h08, 6'h00, 1'b0);
        row(1'b0, 1'b1, pk(4'd10, 3'b010, 1'b1, 2'b10, 1'b0, 2'b00, 9'b0));
        row(1'b0, 1'b1, pk(4'd11, 3'b010, 1'b0, 2'b00, 1'b0, 2'b00, 9'b000000101));
        // lw: fetch stalls once, MEM_RD stalls twice
        cur_op = 6'h23;
        row(1'b0, 1'b0, e_fetch(1'b0));
        begin_instr(6'h23, 6'h00, 1'b0);
        row(1'b0, 1'b1, pk(4'd2, 3'b010, 1'b1, 2'b10, 1'b0, 2'b00, 9'b0));
        row(1'b0, 1'b0, pk(4'd3, 3'b010, 1'b0, 2'b00, 1'b0, 2'b00, 9'b110000000));
        row(1'b0, 1'b0, pk(4'd3, 3'b010, 1'b0, 2'b00, 1'b0, 2'b00, 9'b110000000));
        row(1'b0, 1'b1, pk(4'd3, 3'b010, 1'b0, 2'b00, 1'b0, 2'b00, 9'b110000000));
        row(1'b0, 1'b1, pk(4'd4, 3'b010, 1'b0, 2'b00, 1'b0, 2'b00, 9'b000001101));
        // sw without and with a MEM_WR stall
        begin_instr(6'h2B, 6'h00, 1'b0);
        row(1'b0, 1'b1, pk(4'd2, 3'b010, 1'b1, 2'b10, 1'b0, 2'b00, 9'b0));
        row(1'b0, 1'b1, pk(4'd5, 3'b010, 1'b0, 2'b00, 1'b0, 2'b00, 9'b101000001));
        begin_instr(6'h2B, 6'h00, 1'b0);
        row(1'b0, 1'b1, pk(4'd2, 3'b010, 1'b1, 2'b10, 1'b0, 2'b00, 9'b0));
        row(1'b0, 1'b0, pk(4'd5, 3'b010, 1'b0, 2'b00, 1'b0, 2'b00, 9'b101000000));
        row(1'b0, 1'b1, pk(4'd5, 3'b010, 1'b0, 2'b00, 1'b0, 2'b00, 9'b101000001));
        // beq taken, then not taken; mem_ready low in BRANCH must be ignored
        begin_instr(6'h04, 6'h00, 1'b1);
        row(1'b0, 1'b0, pk(4'd8, 3'b110, 1'b1, 2'b00, 1'b1, 2'b01, 9'b000000001));
        begin_instr(6'h04, 6'h00, 1'b0);
        row(1'b0, 1'b1, pk(4'd8, 3'b110, 1'b1, 2'b00, 1'b0, 2'b01, 9'b000000001));
        begin_instr(6'h02, 6'h00, 1'b0);
        row(1'b0, 1'b1, pk(4'd9, 3'b010, 1'b0, 2'b00, 1'b1, 2'b10, 9'b000000001));
        // illegal opcode: decode pulses illegal and drops back to fetch
        cur_op = 6'h3F; cur_fn = 6'h00; cur_z = 1'b0;
        row(1'b0, 1'b1, e_fetch(1'b1));
        row(1'b0, 1'b1, e_decode(1'b1));
        // lw abandoned by a 3-cycle reset in MEM_RD
        begin_instr(6'h23, 6'h00, 1'b0);
        row(1'b0, 1'b1, pk(4'd2, 3'b010, 1'b1, 2'b10, 1'b0, 2'b00, 9'b0));
        row(1'b0, 1'b0, pk(4'd3, 3'b010, 1'b0, 2'b00, 1'b0, 2'b00, 9'b110000000));
        row(1'b1, 1'b1, pk(4'd3, 3'b010, 1'b0, 2'b00, 1'b0, 2'b00, 9'b0));
        row(1'b1, 1'b1, pk(4'd0, 3'b010, 1'b0, 2'b00, 1'b0, 2'b00, 9'b0));
        row(1'b1, 1'b1, pk(4'd0, 3'b010, 1'b0, 2'b00, 1'b0, 2'b00, 9'b0));
        rtype(6'h20, 3'b010);

        reset = 1'b1;
        repeat (2) @(posedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset = vecs[i].rst; opcode = vecs[i].op; funct = vecs[i].fn;
            zero = vecs[i].z; mem_ready = vecs[i].rdy;
            #1;
            checks++;
            if (act !== vecs[i].exp) begin
                errors++;
                $display("FAIL row %0d: got %b expected %b", i, act, vecs[i].exp);
            end
        end

        // mul with MUL_EN=0 is illegal; the MUL_EN=1 instance takes it
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        @(negedge clk); reset = 1'b0; opcode = 6'h00; funct = 6'h18; mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk); #1;
        chk("nm_exec_state", {4'd0, n_state_o}, 8'd6);
        chk("nm_exec_illegal", {7'd0, n_illegal_instr}, 8'd1);
        chk("mul_select", {5'd0, alu_select}, 8'd5);
        chk("mul_legal", {7'd0, illegal_instr}, 8'd0);
        @(negedge clk); #1;
        chk("nm_after_state", {4'd0, n_state_o}, 8'd0);
        chk("nm_after_illegal", {7'd0, n_illegal_instr}, 8'd0);
        chk("nm_after_writes", {5'd0, n_reg_write, n_mem_write, n_instr_retired}, 8'd0);
        chk("mul_wb_state", {4'd0, state_o}, 8'd7);
        chk("mul_wb_write", {7'd0, reg_write}, 8'd1);

        // unused state 13: all outputs low, back to FETCH on the next clock
        force dut.state_q = state_e'(4'd13);
        #1;
        checks++;
        if (act !== pk(4'd13, 3'b000, 1'b0, 2'b00, 1'b0, 2'b00, 9'b0)) begin
            errors++;
            $display("FAIL unused_state_outputs: got %b expected %b", act,
                     pk(4'd13, 3'b000, 1'b0, 2'b00, 1'b0, 2'b00, 9'b0));
        end
        release dut.state_q;
        @(posedge clk); #1;
        chk("unused_state_next", {4'd0, state_o}, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
